// File: rtl/trace_capture_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_buffer_if
// Purpose  : Sample bus and indexed read-back bus of the trace capture buffer.
//            The master side (core / debug host) drives samples and read
//            requests; the slave side (the buffer) returns read data.
// Signals  : sample_valid, sample_pc, sample_instr, sample_state,
//            sample_memwrite, rd_en, rd_idx   (master -> slave)
//            rd_data, rd_valid                 (slave -> master)
// Options  : TRACE_TIMESTAMP_EN widens rd_data by TS_W bits.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_capture_buffer_if #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 32,
  parameter int STATE_W = 4,
  parameter int TS_W    = 16
);
  localparam int IW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int E = TS_W + 1 + STATE_W + 2 * ADDR_W;
`else
  localparam int E = 1 + STATE_W + 2 * ADDR_W + 0 * TS_W;
`endif

  logic               sample_valid;
  logic [ADDR_W-1:0]  sample_pc;
  logic [ADDR_W-1:0]  sample_instr;
  logic [STATE_W-1:0] sample_state;
  logic               sample_memwrite;
  logic               rd_en;
  logic [IW-1:0]      rd_idx;
  logic [E-1:0]       rd_data;
  logic               rd_valid;

  modport master (
    output sample_valid, sample_pc, sample_instr, sample_state, sample_memwrite,
    output rd_en, rd_idx,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample_valid, sample_pc, sample_instr, sample_state, sample_memwrite,
    input  rd_en, rd_idx,
    output rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_buffer
// Purpose  : On-chip trace recorder for the multicycle ARM core. Records
//            {memwrite, state, instr, pc} on each qualified sample into a
//            circular buffer, stops POST_TRIG samples after a PC match, and
//            allows indexed read-back where index 0 is the oldest entry.
// Ports    : clk, reset (async, active low)
//            arm, trig_en, trig_pc         capture control
//            bus (slave)                   sample input and read-back
//            busy, done, triggered, wrapped, trig_slot, sample_count  status
// Options  : TRACE_TIMESTAMP_EN adds a TS_W-bit cycle stamp to each entry.
// Revision : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int STATE_W   = 4,
  parameter int POST_TRIG = 8,
  parameter int TS_W      = 16,
  localparam int IW       = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              arm,
  input  wire logic              trig_en,
  input  wire logic [ADDR_W-1:0] trig_pc,
  trace_capture_buffer_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   triggered,
  output logic                   wrapped,
  output logic [IW-1:0]          trig_slot,
  output logic [IW:0]            sample_count
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int E = TS_W + 1 + STATE_W + 2 * ADDR_W;
`else
  // TS_W contributes nothing without the timestamp feature.
  localparam int E = 1 + STATE_W + 2 * ADDR_W + 0 * TS_W;
`endif

  localparam logic [IW-1:0] LAST_SLOT = IW'(DEPTH - 1);
  localparam logic [IW:0]   FULL      = (IW + 1)'(DEPTH);
  localparam logic [IW-1:0] POST_LOAD = IW'(POST_TRIG);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] post_cnt;
  logic [E-1:0]  mem [DEPTH];

  logic          capturing;
  logic          accept;
  logic          hit;
  logic [E-1:0]  entry;
  logic [IW-1:0] oldest;
  logic [IW-1:0] rd_slot;
  logic          rd_in_range;

  assign capturing = (state == S_ARMED) || (state == S_POST);
  // arm wins over a coincident sample so a restart never keeps stale data.
  assign accept    = bus.sample_valid && capturing && !arm;
  assign hit       = accept && (state == S_ARMED) && trig_en &&
                     (bus.sample_pc == trig_pc);

`ifdef TRACE_TIMESTAMP_EN
  // ts_now reads 0 in the arm cycle itself, so a stamp equals the number of
  // cycles elapsed since arm (modulo 2**TS_W).
  logic [TS_W-1:0] ts_reg;
  logic [TS_W-1:0] ts_now;

  assign ts_now = arm ? '0 : ts_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_now + 1'b1;
    end
  end

  assign entry = {ts_now, bus.sample_memwrite, bus.sample_state,
                  bus.sample_instr, bus.sample_pc};
`else
  assign entry = {bus.sample_memwrite, bus.sample_state,
                  bus.sample_instr, bus.sample_pc};
`endif

  assign busy = capturing;
  assign done = (state == S_DONE);

  // Capture control and bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      post_cnt     <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      triggered    <= 1'b0;
      trig_slot    <= '0;
    end else if (arm) begin
      state        <= S_ARMED;
      wr_ptr       <= '0;
      post_cnt     <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      triggered    <= 1'b0;
      trig_slot    <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (wr_ptr == LAST_SLOT) begin
        wrapped <= 1'b1;
      end
      if (sample_count != FULL) begin
        sample_count <= sample_count + 1'b1;
      end
      if (hit) begin
        triggered <= 1'b1;
        trig_slot <= wr_ptr;
        post_cnt  <= POST_LOAD;
        state     <= (POST_TRIG == 0) ? S_DONE : S_POST;
      end else if (state == S_POST) begin
        post_cnt <= post_cnt - 1'b1;
        if (post_cnt == IW'(1)) begin
          state <= S_DONE;
        end
      end
    end
  end

  // Trace RAM: no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Once wrapped, the next slot to be written is the oldest surviving entry.
  assign oldest      = wrapped ? wr_ptr : '0;
  assign rd_slot     = oldest + bus.rd_idx;
  assign rd_in_range = ({1'b0, bus.rd_idx} < sample_count);

  // Registered read: a same-cycle write to rd_slot is not yet visible, so
  // the previous contents are returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_in_range ? mem[rd_slot] : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_capture_buffer
// Purpose  : Directed self-checking bench for trace_capture_buffer with
//            DEPTH=8, POST_TRIG=2, TS_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_capture_buffer;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 32;
  localparam int STATE_W   = 4;
  localparam int POST_TRIG = 2;
  localparam int TS_W      = 4;
  localparam int IW        = 3;
  localparam int BASE_E    = 1 + STATE_W + 2 * ADDR_W;   // 69

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0;
  logic              trig_en = 1'b0;
  logic [ADDR_W-1:0] trig_pc = '0;
  logic              busy, done, triggered, wrapped;
  logic [IW-1:0]     trig_slot;
  logic [IW:0]       sample_count;

  int checks = 0;
  int errors = 0;

  trace_capture_buffer_if #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STATE_W(STATE_W), .TS_W(TS_W)
  ) tif ();

  trace_capture_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STATE_W(STATE_W),
    .POST_TRIG(POST_TRIG), .TS_W(TS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .trig_en      (trig_en),
    .trig_pc      (trig_pc),
    .bus          (tif.slave),
    .busy         (busy),
    .done         (done),
    .triggered    (triggered),
    .wrapped      (wrapped),
    .trig_slot    (trig_slot),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample k carries pc=4k, instr=E0000000+k, state=k[3:0], memwrite=k[0].
  function automatic logic [BASE_E-1:0] ent(input int k);
    logic [31:0] kk;
    kk = k;
    return {kk[0], kk[3:0], 32'hE000_0000 + kk, kk << 2};
  endfunction

  task automatic send(input int k);
    logic [BASE_E-1:0] e;
    e = ent(k);
    tif.sample_valid    = 1'b1;
    tif.sample_pc       = e[31:0];
    tif.sample_instr    = e[63:32];
    tif.sample_state    = e[67:64];
    tif.sample_memwrite = e[68];
    tick();
    tif.sample_valid    = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [127:0] data,
                    output logic valid);
    tif.rd_en  = 1'b1;
    tif.rd_idx = IW'(idx);
    tick();
    tif.rd_en  = 1'b0;
    data  = 128'(tif.rd_data);
    valid = tif.rd_valid;
  endtask

  initial begin
    logic [127:0] d;
    logic         v;

    tif.sample_valid    = 1'b1;
    tif.sample_pc       = '0;
    tif.sample_instr    = '0;
    tif.sample_state    = '0;
    tif.sample_memwrite = 1'b0;
    tif.rd_en           = 1'b0;
    tif.rd_idx          = '0;

    // ---- reset held low ----
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_triggered", triggered, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_count", sample_count, 0);
    check("rst_rd_valid", tif.rd_valid, 0);
    check("rst_rd_data", tif.rd_data, 0);
    reset = 1'b1;
    repeat (2) tick();               // sample_valid high while IDLE
    check("idle_count", sample_count, 0);
    tif.sample_valid = 1'b0;

    // ---- basic trigger ----
    trig_en = 1'b1;
    trig_pc = 32'h10;
    arm = 1'b1; tick(); arm = 1'b0;
    check("armed_busy", busy, 1);
    for (int k = 0; k <= 4; k++) send(k);
    check("t1_triggered", triggered, 1);
    check("t1_trig_slot", trig_slot, 4);
    check("t1_post_busy", busy, 1);
    send(5);
    check("t1_not_done_yet", done, 0);
    send(6);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_count", sample_count, 7);
    check("t1_wrapped", wrapped, 0);
    send(7);                          // ignored in DONE
    check("t1_done_ignore", sample_count, 7);
    rd(7, d, v);
    check("t1_rd7_valid", v, 1);
    check("t1_rd7_data", d, 0);
    rd(4, d, v);
    check("t1_rd4_entry", d[BASE_E-1:0], ent(4));
    tick();
    check("t1_rd_valid_low", tif.rd_valid, 0);
    check("t1_rd_hold", tif.rd_data[BASE_E-1:0], ent(4));
    rd(0, d, v);
    check("t1_rd0_valid", v, 1);
    check("t1_rd0_pc", d[31:0], 32'h0);

    // ---- wrap ----
    trig_pc = 32'h40;
    arm = 1'b1; tick(); arm = 1'b0;
    check("t2_rearm_count", sample_count, 0);
    for (int k = 0; k <= 18; k++) send(k);
    check("t2_trig_slot", trig_slot, 0);
    check("t2_triggered", triggered, 1);
    check("t2_done", done, 1);
    check("t2_wrapped", wrapped, 1);
    check("t2_count", sample_count, 8);
    rd(0, d, v);
    check("t2_rd0_pc", d[31:0], 32'h2C);
    rd(5, d, v);
    check("t2_rd5_pc", d[31:0], 32'h40);
    rd(7, d, v);
    check("t2_rd7_entry", d[BASE_E-1:0], ent(18));

    // ---- re-arm with coincident sample ----
    arm = 1'b1;
    tif.sample_valid = 1'b1;
    tif.sample_pc    = 32'h99;
    tick();
    arm = 1'b0;
    tif.sample_valid = 1'b0;
    check("t3_busy", busy, 1);
    check("t3_done", done, 0);
    check("t3_triggered", triggered, 0);
    check("t3_wrapped", wrapped, 0);
    check("t3_count", sample_count, 0);
    send(64);                         // pc 0x100
    check("t3_count1", sample_count, 1);
    rd(0, d, v);
    check("t3_rd0_pc", d[31:0], 32'h100);

    // ---- reset mid-POST ----
    trig_pc = 32'h200;
    send(128);                        // trigger, post_cnt=2
    check("t4_triggered", triggered, 1);
    send(129);                        // post_cnt=1
    check("t4_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_count", sample_count, 0);
    check("t4_triggered_clr", triggered, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t4_stays_idle", busy, 0);

`ifdef TRACE_TIMESTAMP_EN
    // ---- timestamps: arm is cycle 0 ----
    trig_en = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;   // cycle 0
    repeat (2) tick();                // cycles 1,2
    send(1);                          // cycle 3
    repeat (6) tick();                // cycles 4..9
    send(2);                          // cycle 10
    repeat (6) tick();                // cycles 11..16
    send(3);                          // cycle 17 -> wraps to 1
    rd(0, d, v);
    check("ts_entry0", d[BASE_E+TS_W-1:BASE_E], 3);
    check("ts_entry0_pc", d[31:0], 32'h4);
    rd(1, d, v);
    check("ts_entry1", d[BASE_E+TS_W-1:BASE_E], 10);
    rd(2, d, v);
    check("ts_entry2", d[BASE_E+TS_W-1:BASE_E], 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Synthesizable on-chip trace recorder for the multicycle ARM core. It replaces the bench-only per-cycle display monitor with hardware that can run in FPGA builds.
- Captures {MemWrite, FSM state, Instr, PC} on each qualified sample (normally the fetch/IRWrite strobe) into a circular buffer of parametrised depth.
- Supports a PC-match trigger with a configurable post-trigger window. Contents are read back afterwards through an indexed port, where index 0 is always the oldest entry.

Parameters:
- DEPTH, 16: number of entries; power of 2, at least 4.
- ADDR_W, 32: width of PC and Instr.
- STATE_W, 4: width of the FSM state field.
- POST_TRIG, 8: samples recorded after the trigger sample; range 0..DEPTH-1.
- TS_W, 16: timestamp width; used only when TRACE_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; starts (or restarts) a capture.
- trig_en  in  1  enables PC-match triggering.
- trig_pc  in  ADDR_W  PC value to match.
- sample_valid  in  1  qualifies the sample_* inputs this cycle.
- sample_pc  in  ADDR_W  PC to record.
- sample_instr  in  ADDR_W  Instr to record.
- sample_state  in  STATE_W  FSM state to record.
- sample_memwrite  in  1  MemWrite to record.
- rd_en  in  1  read request.
- rd_idx  in  log2(DEPTH)  entry index relative to the oldest entry.
- rd_data  out  E  entry read out. E = 1+STATE_W+2*ADDR_W (+TS_W with the feature); packed MSB to LSB as {ts, memwrite, state, instr, pc}.
- rd_valid  out  1  one-cycle strobe marking valid rd_data.
- busy  out  1  high in ARMED or POST.
- done  out  1  high in DONE.
- triggered  out  1  trigger has fired in the current capture.
- wrapped  out  1  buffer has overwritten at least one entry.
- trig_slot  out  log2(DEPTH)  physical slot holding the trigger sample.
- sample_count  out  log2(DEPTH)+1  entries held; saturates at DEPTH.

Behaviour:
- Reset (asserted low, asynchronous): FSM goes to IDLE. wr_ptr, post_cnt and every output are cleared to 0. Buffer RAM contents are not cleared.
- FSM states: IDLE, ARMED, POST, DONE.
- arm in any state:
  - Next state is ARMED.
  - Clears wr_ptr, sample_count, wrapped, triggered and trig_slot.
  - A sample_valid in the same cycle as arm is ignored.
- IDLE and DONE: sample_valid is ignored.
- ARMED, on sample_valid:
  - Write the entry to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH. When wr_ptr wraps DEPTH-1 to 0, set wrapped.
  - sample_count increments, saturating at DEPTH.
- Trigger (ARMED only), when sample_valid && trig_en && sample_pc == trig_pc:
  - The matching sample is still written.
  - Set triggered; trig_slot = wr_ptr before the increment.
  - post_cnt = POST_TRIG.
  - Next state is DONE if POST_TRIG == 0, otherwise POST.
- POST, on sample_valid:
  - Write the entry exactly as in ARMED; post_cnt decrements.
  - When post_cnt reaches 0, go to DONE. Total entries after the trigger = POST_TRIG.
  - A PC match in POST does not re-trigger.
- Trigger survival: POST_TRIG <= DEPTH-1, so the trigger entry is never overwritten.
- Read path:
  - rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1.
  - Physical slot = (oldest + rd_idx) mod DEPTH, where oldest = wrapped ? wr_ptr : 0.
  - If rd_idx >= sample_count, rd_data = 0 and rd_valid is still 1.
  - Reads are legal in every state.
  - A read of the slot written in the same cycle returns the old contents.
  - rd_data holds its value between reads; rd_valid is low otherwise.
- Reset mid-capture: capture is abandoned immediately; next state is IDLE.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit free-running cycle counter is cleared on arm and increments every cycle, wrapping naturally.
  - Each entry stores the counter value at the sample cycle in the top TS_W bits of rd_data.
- Not defined: no counter is built, and E excludes TS_W.

Test Plan:
- Reset (DEPTH=8, POST_TRIG=2): hold reset low → busy, done, triggered, wrapped, sample_count, rd_valid and rd_data all 0. A sample_valid in IDLE leaves sample_count at 0.
- Basic trigger:
  - Stimulus: arm, trig_en=1, trig_pc=0x10, then samples PC 0x0,0x4,0x8,0xC,0x10,0x14,0x18.
  - Trigger at 0x10 → trig_slot=4; DONE after 0x18 → sample_count=7, wrapped=0.
  - A further sample 0x1C is ignored.
  - rd_idx=0 → pc field 0x0 one cycle after rd_en; rd_idx=7 → rd_data 0.
- Wrap:
  - Stimulus: arm, trig_pc=0x40, then 19 samples with PC=4k for k=0..18.
  - Trigger at k=16 → trig_slot=0; DONE after k=18 → wrapped=1, sample_count=8.
  - rd_idx=0 → pc 0x2C; rd_idx=5 → pc 0x40 (trigger); rd_idx=7 → pc 0x48.
- Re-arm and arm collision:
  - In DONE, pulse arm with sample_valid high → ARMED, sample_count=0, done=0, triggered=0; the coincident sample is not stored.
- Reset mid-POST: assert reset after the trigger with post_cnt=1 → asynchronously IDLE with busy=0, done=0, sample_count=0.
- TRACE_TIMESTAMP_EN: arm at cycle 0, samples at cycles 3 and 10 → ts fields 3 and 10. With TS_W=4, a sample at cycle 17 → ts 1.
